// File: rtl/request_unit_arb.sv
// Round-robin request unit: latches per-channel data requests on ihit and serialises them
// onto one memory read/write strobe pair, with sticky fetch halt and an access watchdog.
module request_unit_arb #(
    parameter int NCH     = 2,
    parameter int SELW    = (NCH > 1) ? $clog2(NCH) : 1,
    parameter int TO_W    = 8,
    parameter int TIMEOUT = 200
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            ihit,
    input  logic            dhit,
    input  logic            halt,
    input  logic [NCH-1:0]  dREN,
    input  logic [NCH-1:0]  dWEN,
    output logic            imemREN,
    output logic            dmemREN,
    output logic            dmemWEN,
    output logic [SELW-1:0] dsel,
    output logic [NCH-1:0]  dhit_ch,
    output logic            busy,
    output logic            timeout
);
    typedef enum logic {IDLE = 1'b0, ACCESS = 1'b1} state_t;

    state_t          state, next_state;
    logic [NCH-1:0]  pend, wr;
    logic [SELW-1:0] last, grant;
    logic [SELW:0]   scan;
    logic            grant_vld;
    logic [TO_W-1:0] wdcnt;
    logic            done;

    assign done = (state == ACCESS) && dhit;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state <= IDLE;
        else     state <= next_state;
    end

    // Scan starts one past the last served channel, so every pending channel is reached
    // within NCH-1 accesses.
    always_comb begin
        grant     = '0;
        grant_vld = 1'b0;
        scan      = '0;
        for (int i = 1; i <= NCH; i++) begin
            scan = {1'b0, last} + (SELW+1)'(i);
            if (scan >= (SELW+1)'(NCH)) scan = scan - (SELW+1)'(NCH);
            if (!grant_vld && pend[scan[SELW-1:0]]) begin
                grant     = scan[SELW-1:0];
                grant_vld = 1'b1;
            end
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (grant_vld) next_state = ACCESS;
            ACCESS:  if (dhit)      next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        dmemREN = 1'b0;
        dmemWEN = 1'b0;
        dhit_ch = '0;
        if (state == ACCESS) begin
            dmemWEN = wr[dsel];
            dmemREN = !wr[dsel];
            if (dhit) dhit_ch = NCH'(1) << dsel;
        end
    end

    assign busy = (|pend) || (state == ACCESS);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            dsel    <= '0;
            last    <= SELW'(NCH - 1);
            wdcnt   <= '0;
            timeout <= 1'b0;
        end else begin
            if (state == IDLE && grant_vld) begin
                dsel  <= grant;
                wdcnt <= '0;
            end
            if (done) last <= dsel;
            // The watchdog only flags; the stalled access keeps its strobe.
            if (state == ACCESS && !dhit) begin
                if (wdcnt != '1) wdcnt <= wdcnt + TO_W'(1);
                if (wdcnt == TO_W'(TIMEOUT - 1)) timeout <= 1'b1;
            end
        end
    end

    // A channel cannot be recaptured while pending, including its own dhit cycle.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            pend <= '0;
            wr   <= '0;
        end else begin
            for (int c = 0; c < NCH; c++) begin
                if (done && dsel == SELW'(c)) begin
                    pend[c] <= 1'b0;
                end else if (ihit && (dREN[c] || dWEN[c]) && !pend[c]) begin
                    pend[c] <= 1'b1;
                    wr[c]   <= dWEN[c];
                end
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST)       imemREN <= 1'b1;
        else if (halt) imemREN <= 1'b0;
    end

endmodule

// File: tb/tb_request_unit_arb.sv
// Directed bench for request_unit_arb (NCH=2, TIMEOUT=4); grants and routed hits are
// checked by a negedge monitor against queues filled by the stimulus process.
module tb_request_unit_arb;
    logic       CLK, RST, ihit, dhit, halt;
    logic [1:0] dREN, dWEN;
    logic       imemREN, dmemREN, dmemWEN, busy, timeout;
    logic [0:0] dsel;
    logic [1:0] dhit_ch;

    request_unit_arb #(.NCH(2), .TO_W(8), .TIMEOUT(4)) dut (
        .CLK(CLK), .RST(RST), .ihit(ihit), .dhit(dhit), .halt(halt),
        .dREN(dREN), .dWEN(dWEN), .imemREN(imemREN), .dmemREN(dmemREN),
        .dmemWEN(dmemWEN), .dsel(dsel), .dhit_ch(dhit_ch), .busy(busy),
        .timeout(timeout)
    );

    typedef struct { int sel; bit wr; int cyc; } grant_t;
    typedef struct { int ch; int cyc; } hit_t;

    grant_t gq[$];
    hit_t   hq[$];
    int     nvec = 0, nerr = 0, cyc = 0;
    logic   prev_strobe = 1'b0;
    grant_t g;
    hit_t   h;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle_inputs();
        ihit = 1'b0; dhit = 1'b0; halt = 1'b0; dREN = 2'b00; dWEN = 2'b00;
    endtask

    // Monitor: a rising strobe is a new grant; a nonzero dhit_ch is a routed hit.
    always @(negedge CLK) begin
        check("strobe_exclusive", {31'd0, dmemREN & dmemWEN}, 32'd0);
        if ((dmemREN | dmemWEN) && !prev_strobe) begin
            if (gq.size() == 0) begin
                check("grant_unexpected", 32'd1, 32'd0 + gq.size());
            end else begin
                g = gq.pop_front();
                check("grant_dsel", {31'd0, dsel}, g.sel);
                check("grant_wen", {31'd0, dmemWEN}, {31'd0, g.wr});
                check("grant_ren", {31'd0, dmemREN}, {31'd0, !g.wr});
                check("grant_cycle", cyc, g.cyc);
            end
        end
        if (dhit_ch != 2'b00) begin
            if (hq.size() == 0) begin
                check("hit_unexpected", {30'd0, dhit_ch}, 32'd0);
            end else begin
                h = hq.pop_front();
                check("hit_ch", {30'd0, dhit_ch}, h.ch);
                check("hit_cycle", cyc, h.cyc);
            end
        end
        prev_strobe = dmemREN | dmemWEN;
    end

    initial begin
        int c;
        RST = 1'b1;
        idle_inputs();

        // Reset held with random inputs.
        for (int i = 0; i < 4; i++) begin
            tick();
            ihit = 1'($urandom); dhit = 1'($urandom); halt = 1'($urandom);
            dREN = 2'($urandom); dWEN = 2'($urandom);
            #1;
            check("rst_imemREN", {31'd0, imemREN}, 32'd1);
            check("rst_strobes", {30'd0, dmemREN, dmemWEN}, 32'd0);
            check("rst_dhit_ch", {30'd0, dhit_ch}, 32'd0);
            check("rst_busy_to", {30'd0, busy, timeout}, 32'd0);
            check("rst_dsel", {31'd0, dsel}, 32'd0);
        end
        tick();
        idle_inputs();
        RST = 1'b0;
        // Released with no requests; a dhit while idle must be ignored.
        for (int i = 0; i < 3; i++) begin
            tick();
            dhit = (i == 1);
            #1;
            check("idle_dmemREN", {31'd0, dmemREN}, 32'd0);
            check("idle_dhit_ch", {30'd0, dhit_ch}, 32'd0);
            check("idle_busy", {31'd0, busy}, 32'd0);
        end

        // Arbitration: ch0 read and ch1 write captured together.
        tick(); dhit = 1'b0;
        c = cyc; ihit = 1'b1; dREN = 2'b01; dWEN = 2'b10;
        gq.push_back('{0, 1'b0, c + 2});
        tick(); idle_inputs();
        tick();
        tick(); dhit = 1'b1;
        hq.push_back('{1, c + 3});
        gq.push_back('{1, 1'b1, c + 5});
        tick(); dhit = 1'b0;
        tick(); dhit = 1'b1;
        hq.push_back('{2, c + 5});
        // Both pending again: channel 0 goes first after channel 1 was served.
        tick(); dhit = 1'b0;
        c = cyc; ihit = 1'b1; dREN = 2'b01; dWEN = 2'b10;
        gq.push_back('{0, 1'b0, c + 2});
        tick(); idle_inputs();
        tick(); dhit = 1'b1;
        hq.push_back('{1, c + 2});
        gq.push_back('{1, 1'b1, c + 4});
        tick(); dhit = 1'b0;
        tick(); dhit = 1'b1;
        hq.push_back('{2, c + 4});
        tick(); dhit = 1'b0;

        // Write priority on channel 0 (only pending channel).
        c = cyc; ihit = 1'b1; dREN = 2'b01; dWEN = 2'b01;
        gq.push_back('{0, 1'b1, c + 2});
        tick(); idle_inputs();
        tick(); dhit = 1'b1;
        hq.push_back('{1, c + 2});
        tick(); dhit = 1'b0;

        // Single read: strobe in cycle 2, dhit in cycle 4, idle in cycle 5.
        c = cyc; ihit = 1'b1; dREN = 2'b01;
        gq.push_back('{0, 1'b0, c + 2});
        tick(); idle_inputs();
        check("read_busy_c1", {31'd0, busy}, 32'd1);
        tick();
        tick();
        tick(); dhit = 1'b1;
        hq.push_back('{1, c + 4});
        tick(); dhit = 1'b0;
        check("read_dmemREN_c5", {31'd0, dmemREN}, 32'd0);
        check("read_busy_c5", {31'd0, busy}, 32'd0);

        // Watchdog: channel 1 read stalls; timeout from the 5th access cycle.
        c = cyc; ihit = 1'b1; dREN = 2'b10;
        gq.push_back('{1, 1'b0, c + 2});
        tick(); idle_inputs();
        for (int k = 2; k <= 7; k++) begin
            tick();
            check("wd_timeout", {31'd0, timeout}, {31'd0, (k >= 6)});
            check("wd_dmemREN_held", {31'd0, dmemREN}, 32'd1);
        end
        tick(); dhit = 1'b1;
        hq.push_back('{2, c + 8});
        tick(); dhit = 1'b0;
        check("wd_timeout_sticky", {31'd0, timeout}, 32'd1);
        check("wd_done_busy", {31'd0, busy}, 32'd0);

        // Halt: fetch stops next cycle, captured read still completes.
        c = cyc; ihit = 1'b1; dREN = 2'b01; halt = 1'b1;
        gq.push_back('{0, 1'b0, c + 2});
        tick(); idle_inputs();
        check("halt_imemREN", {31'd0, imemREN}, 32'd0);
        tick();
        tick(); dhit = 1'b1;
        hq.push_back('{1, c + 3});
        tick(); dhit = 1'b0;
        check("halt_imemREN_sticky", {31'd0, imemREN}, 32'd0);
        check("halt_busy", {31'd0, busy}, 32'd0);

        // Reset mid-access: both channels pending, channel 1 granted (last served was 0).
        ihit = 1'b1; dREN = 2'b11;
        tick(); idle_inputs();
        tick();
        check("pre_rst_dmemREN", {31'd0, dmemREN}, 32'd1);
        check("pre_rst_dsel", {31'd0, dsel}, 32'd1);
        RST = 1'b1;
        #1;
        check("midrst_strobes", {30'd0, dmemREN, dmemWEN}, 32'd0);
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_imemREN", {31'd0, imemREN}, 32'd1);
        check("midrst_timeout", {31'd0, timeout}, 32'd0);
        tick();
        tick(); RST = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("post_rst_dmemREN", {31'd0, dmemREN}, 32'd0);
            check("post_rst_busy", {31'd0, busy}, 32'd0);
        end

        check("grants_left", 32'd0 + gq.size(), 32'd0);
        check("hits_left", 32'd0 + hq.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
